// File: rtl/regs_sp_seq.sv
// -----------------------------------------------------------------------------
// regs_sp_seq
//
// Stack-pointer sequencer. While idle it forwards decode's A-port and write-port
// controls straight to the register file. When the control unit requests a
// push or pop, it takes over those ports for a short read-modify-write of the
// 32-bit stack pointer, which is kept in two 16-bit registers: sp_low at
// SP_LO_IDX and sp_high at SP_HI_IDX. It then returns the memory address for
// the access.
//
//   push: SP is pre-decremented by op_step; addr = new SP
//   pop : SP is post-incremented by op_step; addr = old SP
//
// sp_high is rewritten only when the low half carries or borrows.
//
// Ports
//   cpu_clk, cpu_rst_n      clock; asynchronous active-low reset
//   op_valid/op_ready       request handshake (ready only while idle)
//   op_push, op_step        operation type and unsigned byte count
//   done, addr              one-cycle completion pulse; address held until next done
//   stall                   high while an operation is in flight (freezes decode)
//   dec_*                   decode-stage A-port / write-port controls
//   rf_*                    controls driven to the register file
//   rf_a_in                 register file A-port read data (combinational)
// -----------------------------------------------------------------------------
module regs_sp_seq #(
    parameter int unsigned STEP_W    = 4,
    parameter logic [3:0]  SP_LO_IDX = 4'hE,
    parameter logic [3:0]  SP_HI_IDX = 4'hF
) (
    input  logic              cpu_clk,
    input  logic              cpu_rst_n,

    input  logic              op_valid,
    output logic              op_ready,
    input  logic              op_push,
    input  logic [STEP_W-1:0] op_step,
    output logic              done,
    output logic [31:0]       addr,
    output logic              stall,

    input  logic              dec_src_a_en,
    input  logic [3:0]        dec_src_a,
    input  logic [3:0]        dec_src_w,
    input  logic [15:0]       dec_val,

    output logic              rf_src_a_en,
    output logic [3:0]        rf_src_a,
    output logic [3:0]        rf_src_w,
    output logic [15:0]       rf_val,
    input  logic [15:0]       rf_a_in
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD_LO = 3'd1,
        WR_LO = 3'd2,
        RD_HI = 3'd3,
        WR_HI = 3'd4,
        DONE  = 3'd5
    } state_t;

    state_t              state_reg;
    logic                push_reg;
    logic [STEP_W-1:0]   step_reg;
    logic [15:0]         old_lo_reg;
    logic [15:0]         new_lo_reg;
    logic [15:0]         old_hi_reg;
    logic                cy_reg;
    logic [31:0]         addr_reg;
    logic                done_reg;

    logic [16:0]         step_ext;
    logic [16:0]         lo_sum;
    logic [15:0]         hi_next;

    // The step is zero-extended to 17 bits. This makes bit 16 of the result
    // the borrow for a subtraction and the carry for an addition, so one
    // flag covers both directions.
    assign step_ext = {{(17 - STEP_W){1'b0}}, step_reg};
    assign lo_sum   = push_reg ? ({1'b0, old_lo_reg} - step_ext)
                               : ({1'b0, old_lo_reg} + step_ext);

    // The high half moves by exactly one, wrapping modulo 2^16. This makes
    // the full 32-bit SP wrap.
    assign hi_next  = push_reg ? (old_hi_reg - 16'd1) : (old_hi_reg + 16'd1);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_reg  <= IDLE;
            push_reg   <= 1'b0;
            step_reg   <= '0;
            old_lo_reg <= 16'h0000;
            new_lo_reg <= 16'h0000;
            old_hi_reg <= 16'h0000;
            cy_reg     <= 1'b0;
            addr_reg   <= 32'h0000_0000;
            done_reg   <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (op_valid) begin
                        push_reg  <= op_push;
                        step_reg  <= op_step;
                        state_reg <= RD_LO;
                    end
                end
                RD_LO: begin
                    old_lo_reg <= rf_a_in;
                    state_reg  <= WR_LO;
                end
                WR_LO: begin
                    new_lo_reg <= lo_sum[15:0];
                    cy_reg     <= lo_sum[16];
                    state_reg  <= RD_HI;
                end
                RD_HI: begin
                    old_hi_reg <= rf_a_in;
                    if (cy_reg) begin
                        state_reg <= WR_HI;
                    end else begin
                        // No carry or borrow, so the high half stays the
                        // same. The address can be formed from the live
                        // read data without a WR_HI cycle.
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                        addr_reg  <= {rf_a_in, (push_reg ? new_lo_reg : old_lo_reg)};
                    end
                end
                WR_HI: begin
                    state_reg <= DONE;
                    done_reg  <= 1'b1;
                    addr_reg  <= push_reg ? {hi_next, new_lo_reg}
                                          : {old_hi_reg, old_lo_reg};
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign op_ready = (state_reg == IDLE);
    assign stall    = (state_reg != IDLE);
    assign done     = done_reg;
    assign addr     = addr_reg;

    // Register-file port mux. The register file writes whenever src_w is
    // non-zero, so every cycle that is not a write leaves src_w at 0.
    always_comb begin
        rf_src_a_en = 1'b0;
        rf_src_a    = 4'h0;
        rf_src_w    = 4'h0;
        rf_val      = 16'h0000;
        case (state_reg)
            IDLE: begin
                rf_src_a_en = dec_src_a_en;
                rf_src_a    = dec_src_a;
                rf_src_w    = dec_src_w;
                rf_val      = dec_val;
            end
            RD_LO: begin
                rf_src_a_en = 1'b1;
                rf_src_a    = SP_LO_IDX;
            end
            WR_LO: begin
                rf_src_w    = SP_LO_IDX;
                rf_val      = lo_sum[15:0];
            end
            RD_HI: begin
                rf_src_a_en = 1'b1;
                rf_src_a    = SP_HI_IDX;
            end
            WR_HI: begin
                rf_src_w    = SP_HI_IDX;
                rf_val      = hi_next;
            end
            default: begin
                rf_src_a_en = 1'b0;
            end
        endcase
        // While reset is asserted the state is already IDLE. Without this
        // gate, decode would still reach the register file, so no read
        // enable or write may leave the block during reset.
        if (!cpu_rst_n) begin
            rf_src_a_en = 1'b0;
            rf_src_a    = 4'h0;
            rf_src_w    = 4'h0;
            rf_val      = 16'h0000;
        end
    end

endmodule

// File: tb/tb_regs_sp_seq.sv
module tb_regs_sp_seq;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        op_valid;
    logic        op_ready;
    logic        op_push;
    logic [3:0]  op_step;
    logic        done;
    logic [31:0] addr;
    logic        stall;
    logic        dec_src_a_en;
    logic [3:0]  dec_src_a;
    logic [3:0]  dec_src_w;
    logic [15:0] dec_val;
    logic        rf_src_a_en;
    logic [3:0]  rf_src_a;
    logic [3:0]  rf_src_w;
    logic [15:0] rf_val;
    logic [15:0] rf_a_in;

    regs_sp_seq #(
        .STEP_W    (4),
        .SP_LO_IDX (4'hE),
        .SP_HI_IDX (4'hF)
    ) dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst_n    (cpu_rst_n),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_push      (op_push),
        .op_step      (op_step),
        .done         (done),
        .addr         (addr),
        .stall        (stall),
        .dec_src_a_en (dec_src_a_en),
        .dec_src_a    (dec_src_a),
        .dec_src_w    (dec_src_w),
        .dec_val      (dec_val),
        .rf_src_a_en  (rf_src_a_en),
        .rf_src_a     (rf_src_a),
        .rf_src_w     (rf_src_w),
        .rf_val       (rf_val),
        .rf_a_in      (rf_a_in)
    );

    always #5 cpu_clk = ~cpu_clk;

    // Register file environment: it writes on every edge where src_w != 0
    // and reads the A port combinationally.
    logic [15:0] rf [16];
    always @(posedge cpu_clk) begin
        if (rf_src_w != 4'h0) rf[rf_src_w] <= rf_val;
    end
    assign rf_a_in = rf[rf_src_a];

    // Event monitors
    int done_cnt  = 0;
    int hi_writes = 0;
    int bad_w     = 0;
    always @(posedge cpu_clk) begin
        if (done === 1'b1) done_cnt++;
        if (rf_src_w == 4'hF) hi_writes++;
        if (stall === 1'b1 && !(rf_src_w == 4'h0 || rf_src_w == 4'hE || rf_src_w == 4'hF)) bad_w++;
    end

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] sp;
        int          lat;
    } exp_t;
    exp_t sb[$];

    // Reference: 32-bit stack-pointer arithmetic.
    function automatic exp_t model(input logic [31:0] sp, input logic push, input logic [3:0] step);
        exp_t e;
        logic [31:0] n;
        n      = push ? (sp - {28'd0, step}) : (sp + {28'd0, step});
        e.sp   = n;
        e.addr = push ? n : sp;
        e.lat  = (n[31:16] != sp[31:16]) ? 5 : 4;
        return e;
    endfunction

    // All helpers start and end just after a falling edge.
    task automatic set_reg(input logic [3:0] idx, input logic [15:0] v);
        dec_src_w = idx;
        dec_val   = v;
        @(negedge cpu_clk);
        dec_src_w = 4'h0;
        dec_val   = 16'h0000;
    endtask

    task automatic start_op(input logic push, input logic [3:0] step);
        sb.push_back(model({rf[15], rf[14]}, push, step));
        op_valid = 1'b1;
        op_push  = push;
        op_step  = step;
        @(negedge cpu_clk);
        op_valid = 1'b0;
    endtask

    // Called in cycle 1 (one cycle after the acceptance edge).
    task automatic wait_done(output int lat, output logic [31:0] a, output bit ok);
        int cyc;
        cyc = 1;
        while (done !== 1'b1 && cyc < 12) begin
            @(negedge cpu_clk);
            cyc++;
        end
        ok  = (done === 1'b1);
        lat = cyc;
        a   = addr;
    endtask

    task automatic test_reset();
        cpu_rst_n    = 1'b0;
        op_valid     = 1'b0;
        op_push      = 1'b0;
        op_step      = 4'h0;
        dec_src_a_en = 1'b1;
        dec_src_a    = 4'h3;
        dec_src_w    = 4'h3;
        dec_val      = 16'h1234;
        repeat (3) @(negedge cpu_clk);
        n_cmp++; if (rf_src_w !== 4'h0) begin n_err++; $display("FAIL reset_rf_src_w got=%h exp=0", rf_src_w); end
        n_cmp++; if (rf_src_a_en !== 1'b0) begin n_err++; $display("FAIL reset_rf_src_a_en got=%b exp=0", rf_src_a_en); end
        n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done got=%b exp=0", done); end
        n_cmp++; if (addr !== 32'h0) begin n_err++; $display("FAIL reset_addr got=%h exp=0", addr); end
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall); end
        dec_src_a_en = 1'b0;
        dec_src_a    = 4'h0;
        dec_src_w    = 4'h0;
        dec_val      = 16'h0000;
        cpu_rst_n    = 1'b1;
        @(negedge cpu_clk);
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL reset_op_ready got=%b exp=1", op_ready); end
        $display("txn reset done");
    endtask

    task automatic test_passthrough();
        set_reg(4'h3, 16'h0000);
        dec_src_w    = 4'h3;
        dec_val      = 16'h1234;
        dec_src_a_en = 1'b1;
        dec_src_a    = 4'h9;
        #1;
        n_cmp++; if (rf_src_w !== 4'h3) begin n_err++; $display("FAIL pass_src_w got=%h exp=3", rf_src_w); end
        n_cmp++; if (rf_val !== 16'h1234) begin n_err++; $display("FAIL pass_val got=%h exp=1234", rf_val); end
        n_cmp++; if (rf_src_a !== 4'h9 || rf_src_a_en !== 1'b1) begin n_err++; $display("FAIL pass_a got=%b/%h exp=1/9", rf_src_a_en, rf_src_a); end
        @(negedge cpu_clk);
        dec_src_w    = 4'h0;
        dec_val      = 16'h0000;
        dec_src_a_en = 1'b0;
        dec_src_a    = 4'h0;
        n_cmp++; if (rf[3] !== 16'h1234) begin n_err++; $display("FAIL pass_r3 got=%h exp=1234", rf[3]); end
        $display("txn passthrough w=3 val=1234 r3=%h", rf[3]);
    endtask

    task automatic test_sp_math();
        logic [31:0] sp_tab [6];
        logic        push_tab [6];
        logic [3:0]  step_tab [6];
        exp_t        e;
        int          lat;
        logic [31:0] a;
        bit          ok;
        int          hw0;
        sp_tab   = '{32'h0000_1000, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h00AB_CDEF, 32'h1234_FFF9};
        push_tab = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        step_tab = '{4'd2, 4'd2, 4'd1, 4'd1, 4'd0, 4'd15};
        for (int i = 0; i < 6; i++) begin
            set_reg(4'hE, sp_tab[i][15:0]);
            set_reg(4'hF, sp_tab[i][31:16]);
            hw0 = hi_writes;
            start_op(push_tab[i], step_tab[i]);
            wait_done(lat, a, ok);
            e = sb.pop_front();
            n_cmp++; if (!ok) begin n_err++; $display("FAIL math%0d_timeout got=no_done exp=done", i); end
            n_cmp++; if (lat != e.lat) begin n_err++; $display("FAIL math%0d_latency got=%0d exp=%0d", i, lat, e.lat); end
            n_cmp++; if (a !== e.addr) begin n_err++; $display("FAIL math%0d_addr got=%h exp=%h", i, a, e.addr); end
            @(negedge cpu_clk);
            n_cmp++; if ({rf[15], rf[14]} !== e.sp) begin n_err++; $display("FAIL math%0d_sp got=%h exp=%h", i, {rf[15], rf[14]}, e.sp); end
            n_cmp++; if ((hi_writes - hw0) != ((e.lat == 5) ? 1 : 0)) begin n_err++; $display("FAIL math%0d_hi_writes got=%0d exp=%0d", i, hi_writes - hw0, (e.lat == 5) ? 1 : 0); end
            $display("txn sp=%h push=%b step=%0d addr=%h lat=%0d new_sp=%h", sp_tab[i], push_tab[i], step_tab[i], a, lat, {rf[15], rf[14]});
        end
    endtask

    task automatic test_stall();
        exp_t        e;
        int          lat;
        logic [31:0] a;
        bit          ok;
        int          bw0;
        set_reg(4'h5, 16'h5555);
        set_reg(4'h6, 16'h0000);
        set_reg(4'hE, 16'h2000);
        set_reg(4'hF, 16'h0000);
        bw0 = bad_w;
        // A decode write in the accept cycle must still happen.
        dec_src_w = 4'h6;
        dec_val   = 16'h6666;
        start_op(1'b0, 4'd1);
        dec_src_w    = 4'h5;
        dec_val      = 16'hBEEF;
        dec_src_a_en = 1'b1;
        dec_src_a    = 4'h7;
        #1;
        n_cmp++; if (rf_src_a !== 4'hE || rf_src_a_en !== 1'b1 || rf_src_w !== 4'h0) begin n_err++; $display("FAIL stall_rd_lo got=%b/%h/%h exp=1/e/0", rf_src_a_en, rf_src_a, rf_src_w); end
        n_cmp++; if (op_ready !== 1'b0 || stall !== 1'b1) begin n_err++; $display("FAIL stall_flags got=%b/%b exp=0/1", op_ready, stall); end
        wait_done(lat, a, ok);
        dec_src_w    = 4'h0;
        dec_val      = 16'h0000;
        dec_src_a_en = 1'b0;
        dec_src_a    = 4'h0;
        e = sb.pop_front();
        n_cmp++; if (!ok || a !== e.addr) begin n_err++; $display("FAIL stall_addr got=%h exp=%h", a, e.addr); end
        @(negedge cpu_clk);
        n_cmp++; if (rf[5] !== 16'h5555) begin n_err++; $display("FAIL stall_r5 got=%h exp=5555", rf[5]); end
        n_cmp++; if (rf[6] !== 16'h6666) begin n_err++; $display("FAIL accept_r6 got=%h exp=6666", rf[6]); end
        n_cmp++; if (bad_w != bw0) begin n_err++; $display("FAIL stall_src_w got=%0d_bad exp=0_bad", bad_w - bw0); end
        $display("txn stall addr=%h r5=%h r6=%h", a, rf[5], rf[6]);
    endtask

    task automatic test_back_to_back();
        exp_t        e;
        int          lat;
        logic [31:0] a;
        bit          ok;
        set_reg(4'hE, 16'hFFFE);
        set_reg(4'hF, 16'h0000);
        sb.push_back(model(32'h0000_FFFE, 1'b0, 4'd3));
        e = sb[0];
        sb.push_back(model(e.sp, 1'b1, 4'd4));
        op_valid = 1'b1;
        op_push  = 1'b0;
        op_step  = 4'd3;
        @(negedge cpu_clk);
        // The request stays up with new fields for the second operation.
        op_push = 1'b1;
        op_step = 4'd4;
        for (int k = 0; k < 2; k++) begin
            wait_done(lat, a, ok);
            e = sb.pop_front();
            n_cmp++; if (!ok || lat != e.lat) begin n_err++; $display("FAIL b2b%0d_latency got=%0d exp=%0d", k, lat, e.lat); end
            n_cmp++; if (a !== e.addr) begin n_err++; $display("FAIL b2b%0d_addr got=%h exp=%h", k, a, e.addr); end
            $display("txn b2b%0d addr=%h lat=%0d", k, a, lat);
            @(negedge cpu_clk);
            if (k == 0) begin
                n_cmp++; if (op_ready !== 1'b1 || stall !== 1'b0) begin n_err++; $display("FAIL b2b_idle got=%b/%b exp=1/0", op_ready, stall); end
                @(negedge cpu_clk);
                op_valid = 1'b0;
                n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL b2b_accept got=%b exp=1", stall); end
            end
        end
        n_cmp++; if ({rf[15], rf[14]} !== e.sp) begin n_err++; $display("FAIL b2b_sp got=%h exp=%h", {rf[15], rf[14]}, e.sp); end
    endtask

    task automatic test_reset_mid();
        int d0;
        set_reg(4'hE, 16'hFFFF);
        set_reg(4'hF, 16'h1234);
        op_valid = 1'b1;
        op_push  = 1'b0;
        op_step  = 4'd2;
        @(negedge cpu_clk);
        op_valid = 1'b0;
        @(negedge cpu_clk);
        n_cmp++; if (rf_src_w !== 4'hE) begin n_err++; $display("FAIL rstmid_wr_lo got=%h exp=e", rf_src_w); end
        d0 = done_cnt;
        cpu_rst_n = 1'b0;
        #1;
        n_cmp++; if (rf_src_w !== 4'h0 || stall !== 1'b0) begin n_err++; $display("FAIL rstmid_async got=%h/%b exp=0/0", rf_src_w, stall); end
        repeat (3) @(negedge cpu_clk);
        cpu_rst_n = 1'b1;
        repeat (4) @(negedge cpu_clk);
        n_cmp++; if (op_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_ready got=%b exp=1", op_ready); end
        n_cmp++; if (addr !== 32'h0) begin n_err++; $display("FAIL rstmid_addr got=%h exp=0", addr); end
        n_cmp++; if (done_cnt != d0) begin n_err++; $display("FAIL rstmid_done got=%0d exp=%0d", done_cnt, d0); end
        n_cmp++; if (rf[15] !== 16'h1234 || rf[14] !== 16'hFFFF) begin n_err++; $display("FAIL rstmid_sp got=%h exp=1234ffff", {rf[15], rf[14]}); end
        $display("txn reset_mid sp=%h addr=%h", {rf[15], rf[14]}, addr);
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_sp_math();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
